// File: rtl/async_fifo_if.sv
// Producer/consumer handshake bundle for the byte FIFO; `ASYNC_FIFO_ERR_FLAGS_EN adds the sticky error flags.
interface async_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_count;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, read_en, data_in,
        input  data_out, fifo_full, fifo_empty, fifo_count, overflow, underflow
    );
    modport slave (
        input  write_en, read_en, data_in,
        output data_out, fifo_full, fifo_empty, fifo_count, overflow, underflow
    );
`else
    modport master (
        output write_en, read_en, data_in,
        input  data_out, fifo_full, fifo_empty, fifo_count
    );
    modport slave (
        input  write_en, read_en, data_in,
        output data_out, fifo_full, fifo_empty, fifo_count
    );
`endif
endinterface

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit binary pointers and a registered read port.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    async_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  full, empty;
    logic                  read_accept, write_accept;

    // Flags come only from the registered pointers, never from the enables.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[ADDR_WIDTH] != wr_ptr_q[ADDR_WIDTH]) &&
                   (rd_ptr_q[ADDR_WIDTH-1:0] == wr_ptr_q[ADDR_WIDTH-1:0]);

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign read_accept  = bus.read_en & ~empty;
    assign write_accept = bus.write_en & (~full | read_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (read_accept)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left uncleared by reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && write_accept)
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            data_out_q <= '0;
        else if (read_accept)
            data_out_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    assign bus.data_out   = data_out_q;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.fifo_count = wr_ptr_q - rd_ptr_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (bus.write_en & full & ~read_accept);
        underflow_d = underflow_q | (bus.read_en & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, basic order, full/drop, empty read, full read+write, wrapping stream.
module tb_async_fifo;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    async_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [7:0] din);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_out;
    logic       rd_ok;
    logic       wr_ok;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);

        // 1: reset
        tick(); tick();
        check_eq("rst_empty", 32'(bus.fifo_empty), 32'd1);
        check_eq("rst_full",  32'(bus.fifo_full),  32'd0);
        check_eq("rst_count", 32'(bus.fifo_count), 32'd0);
        check_eq("rst_dout",  32'(bus.data_out),   32'h00);
        reset = 1'b0;

        // 2: two writes, two reads
        drive(1'b1, 1'b0, 8'hCA); tick();
        check_eq("t2_count1", 32'(bus.fifo_count), 32'd1);
        drive(1'b1, 1'b0, 8'hAA); tick();
        check_eq("t2_count2", 32'(bus.fifo_count), 32'd2);
        drive(1'b0, 1'b1, 8'h00); tick();
        check_eq("t2_rd1", 32'(bus.data_out), 32'hCA);
        check_eq("t2_count3", 32'(bus.fifo_count), 32'd1);
        tick();
        check_eq("t2_rd2", 32'(bus.data_out), 32'hAA);
        check_eq("t2_count4", 32'(bus.fifo_count), 32'd0);
        check_eq("t2_empty", 32'(bus.fifo_empty), 32'd1);

        // 3: fill, drop 17th, drain in order
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i)); tick();
        end
        check_eq("t3_full",  32'(bus.fifo_full),  32'd1);
        check_eq("t3_count", 32'(bus.fifo_count), 32'd16);
        drive(1'b1, 1'b0, 8'hFF); tick();
        check_eq("t3_drop_count", 32'(bus.fifo_count), 32'd16);
        check_eq("t3_drop_full",  32'(bus.fifo_full),  32'd1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check_eq("t3_overflow", 32'(bus.overflow), 32'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00); tick();
            check_eq($sformatf("t3_rd%0d", i), 32'(bus.data_out), 32'(i));
        end
        check_eq("t3_empty", 32'(bus.fifo_empty), 32'd1);

        // 4: read while empty
        drive(1'b0, 1'b1, 8'h00); tick();
        check_eq("t4_dout",  32'(bus.data_out),   32'h0F);
        check_eq("t4_count", 32'(bus.fifo_count), 32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        drive(1'b0, 1'b0, 8'h00); tick();
        check_eq("t4_underflow", 32'(bus.underflow), 32'd1);
`endif

        // 5: simultaneous read+write while full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i)); tick();
        end
        check_eq("t5_full0", 32'(bus.fifo_full), 32'd1);
        drive(1'b1, 1'b1, 8'h5A); tick();
        check_eq("t5_full",  32'(bus.fifo_full),  32'd1);
        check_eq("t5_count", 32'(bus.fifo_count), 32'd16);
        check_eq("t5_head",  32'(bus.data_out),   32'h10);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00); tick();
            check_eq($sformatf("t5_rd%0d", i), 32'(bus.data_out), 32'(8'h10 + i));
        end
        tick();
        check_eq("t5_last", 32'(bus.data_out), 32'h5A);
        check_eq("t5_empty", 32'(bus.fifo_empty), 32'd1);

        // 6: interleaved stream with mid-stream reset, checked against a queue model
        q.delete();
        exp_out = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            if (i == 25) begin
                drive(1'b0, 1'b0, 8'h00);
                reset = 1'b1; tick(); reset = 1'b0;
                check_eq("t6_rst_empty", 32'(bus.fifo_empty), 32'd1);
                check_eq("t6_rst_count", 32'(bus.fifo_count), 32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
                check_eq("t6_rst_ovf", 32'(bus.overflow),  32'd0);
                check_eq("t6_rst_udf", 32'(bus.underflow), 32'd0);
`endif
                q.delete();
                exp_out = 8'h00;
            end
            rd_ok = (q.size() > 0) && (i % 3 != 2);
            wr_ok = (i % 5 != 4);
            drive(wr_ok, rd_ok, 8'(8'h80 + i));
            tick();
            if (rd_ok) exp_out = q.pop_front();
            if (wr_ok) q.push_back(8'(8'h80 + i));
            check_eq($sformatf("t6_dout%0d", i),  32'(bus.data_out),   32'(exp_out));
            check_eq($sformatf("t6_count%0d", i), 32'(bus.fifo_count), 32'(q.size()));
        end
        while (q.size() > 0) begin
            drive(1'b0, 1'b1, 8'h00); tick();
            exp_out = q.pop_front();
            check_eq("t6_drain", 32'(bus.data_out), 32'(exp_out));
        end
        check_eq("t6_empty", 32'(bus.fifo_empty), 32'd1);
        drive(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
